// File: rtl/s2p_frame_ctrl_if.sv
// Bit-stream input and word-output handshake bundle for s2p_frame_ctrl.
// The master side drives bits and word_ready; the slave (the deserialiser) returns buffered words.
interface s2p_frame_ctrl_if #(
  parameter int N = 8
);
  logic         bit_in;
  logic         bit_valid;
  logic         word_ready;
  logic [N-1:0] word_data;
  logic         word_valid;
  logic         frame_start;
  logic         frame_end;

  modport master (
    output bit_in, bit_valid, word_ready,
    input  word_data, word_valid, frame_start, frame_end
  );

  modport slave (
    input  bit_in, bit_valid, word_ready,
    output word_data, word_valid, frame_start, frame_end
  );
endinterface

// File: rtl/s2p_frame_ctrl.sv
// Serial-to-parallel framer: hunts for a bit-aligned SYNC word, then assembles FRAME_WORDS
// MSB-first payload words into a 2-entry output FIFO, resyncing whenever a word has to be dropped.
module s2p_frame_ctrl #(
  parameter int           N           = 8,
  parameter logic [N-1:0] SYNC        = 8'hA5,
  parameter int           FRAME_WORDS = 4
) (
  input  logic                clk,
  input  logic                reset,
  s2p_frame_ctrl_if.slave     bus,
  input  logic                clear_ovf,
  output logic                locked,
  output logic                overflow,
  output logic [0:0]          o_dbg_state
);
  // Output handshake: a word moves when word_valid && word_ready in the same cycle;
  // while word_valid=1 and word_ready=0 the head word and its tags stay unchanged.

  localparam logic [0:0] HUNT    = 1'b0;
  localparam logic [0:0] PAYLOAD = 1'b1;

  localparam int BW = $clog2(N);
  localparam int WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);

  logic [0:0]    r_state;
  logic [N-1:0]  r_sr;
  logic [BW-1:0] r_bit_cnt;
  logic [WW-1:0] r_word_cnt;
  logic          r_ovf;

  // FIFO entry layout: {frame_start, frame_end, data}
  logic [N+1:0]  r_mem [2];
  logic          r_rd_ptr;
  logic          r_wr_ptr;
  logic [1:0]    r_count;

  logic [N-1:0]  w_shift;
  logic          w_word_done;
  logic          w_pop;
  logic          w_drop;
  logic          w_push;
  logic          w_tag_start;
  logic          w_tag_end;
  logic [N+1:0]  w_head;

  assign w_shift     = {r_sr[N-2:0], bus.bit_in};
  assign w_word_done = bus.bit_valid && (r_state == PAYLOAD) && (r_bit_cnt == BIT_LAST);
  assign w_pop       = (r_count != 2'd0) && bus.word_ready;
  assign w_drop      = w_word_done && (r_count == 2'd2) && !w_pop;
  assign w_push      = w_word_done && !w_drop;
  assign w_tag_start = (r_word_cnt == '0);
  assign w_tag_end   = (r_word_cnt == WORD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= HUNT;
      r_sr       <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (bus.bit_valid) begin
      if (r_state == HUNT) begin
        r_sr <= w_shift;
        if (w_shift == SYNC) begin
          r_state    <= PAYLOAD;
          r_bit_cnt  <= '0;
          r_word_cnt <= '0;
        end
      end else if (w_word_done) begin
        r_bit_cnt <= '0;
        // A dropped word and the last word of a frame both send us back to hunting from a clean register
        if (w_drop || w_tag_end) begin
          r_state    <= HUNT;
          r_sr       <= '0;
          r_word_cnt <= '0;
        end else begin
          r_sr       <= w_shift;
          r_word_cnt <= r_word_cnt + 1'b1;
        end
      end else begin
        r_sr      <= w_shift;
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      // When full with a simultaneous pop, wr_ptr aliases the slot being read; it is freed this edge
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_tag_start, w_tag_end, w_shift};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clear_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign w_head          = r_mem[r_rd_ptr];
  assign bus.word_valid  = (r_count != 2'd0);
  assign bus.word_data   = bus.word_valid ? w_head[N-1:0] : '0;
  assign bus.frame_start = bus.word_valid && w_head[N+1];
  assign bus.frame_end   = bus.word_valid && w_head[N];
  assign locked          = (r_state == PAYLOAD);
  assign overflow        = r_ovf;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Bench for s2p_frame_ctrl: table-driven frame vectors, hand-written backpressure/reset sequences,
// and randomized bit streams scored against a queue-based reference model.
module tb_s2p_frame_ctrl;
  localparam int         N    = 8;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         FW   = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       clear_ovf;
  logic       locked;
  logic       overflow;
  logic [0:0] dbg_state;

  s2p_frame_ctrl_if #(.N(N)) bus ();

  s2p_frame_ctrl #(.N(N), .SYNC(SYNC), .FRAME_WORDS(FW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .clear_ovf  (clear_ovf),
    .locked     (locked),
    .overflow   (overflow),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic b, input logic v, input logic r, input logic c);
    bus.bit_in     = b;
    bus.bit_valid  = v;
    bus.word_ready = r;
    clear_ovf      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic r);
    for (int i = 7; i >= 0; i--) step(w[i], 1'b1, r, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"},  bus.word_valid,  0);
    chk({tag, ".data"},   bus.word_data,   0);
    chk({tag, ".start"},  bus.frame_start, 0);
    chk({tag, ".end"},    bus.frame_end,   0);
    chk({tag, ".locked"}, locked,          0);
    chk({tag, ".ovf"},    overflow,        0);
  endtask

  task automatic do_reset(input string tag);
    reset          = 1'b1;
    bus.bit_in     = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.word_ready = 1'b0;
    clear_ovf      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero({tag, ".in_rst"});
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_zero({tag, ".post_rst"});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       b, v, r, c;
    logic       ev;
    logic [7:0] ed;
    logic       es, ee, el, eo;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_vec(logic b, logic v, logic r, logic c, logic ev, logic [7:0] ed,
                                  logic es, logic ee, logic el, logic eo);
    vec_t x;
    x.b = b; x.v = v; x.r = r; x.c = c;
    x.ev = ev; x.ed = ed; x.es = es; x.ee = ee; x.el = el; x.eo = eo;
    tbl.push_back(x);
  endfunction

  // Frame 0,1,1 / A5 / 11 22 33 44 with word_ready=1; optional idle cycle after each valid bit.
  function automatic void build_frame(bit toggle);
    logic [7:0] words [4];
    logic [7:0] pre;
    logic       lk;
    logic       last;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    pre = 8'b0000_0011;
    for (int i = 2; i >= 0; i--) begin
      add_vec(pre[i], 1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
      if (toggle) add_vec(0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    end
    for (int i = 7; i >= 0; i--) begin
      lk = (i == 0);
      add_vec(SYNC[i], 1, 1, 0, 0, 8'h00, 0, 0, lk, 0);
      if (toggle) add_vec(0, 0, 1, 0, 0, 8'h00, 0, 0, lk, 0);
    end
    for (int k = 0; k < 4; k++) begin
      for (int i = 7; i >= 0; i--) begin
        last = (i == 0);
        lk   = !(k == 3 && last);
        add_vec(words[k][i], 1, 1, 0, last, last ? words[k] : 8'h00,
                last && (k == 0), last && (k == 3), lk, 0);
        if (toggle) add_vec(0, 0, 1, 0, 0, 8'h00, 0, 0, lk, 0);
      end
    end
    add_vec(0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
  endfunction

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].b, tbl[i].v, tbl[i].r, tbl[i].c);
      chk($sformatf("%s[%0d].valid", tag, i), bus.word_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("%s[%0d].data", tag, i),  bus.word_data,   tbl[i].ed);
        chk($sformatf("%s[%0d].start", tag, i), bus.frame_start, tbl[i].es);
        chk($sformatf("%s[%0d].end", tag, i),   bus.frame_end,   tbl[i].ee);
      end
      chk($sformatf("%s[%0d].locked", tag, i), locked,   tbl[i].el);
      chk($sformatf("%s[%0d].ovf", tag, i),    overflow, tbl[i].eo);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
  } ent_t;

  ent_t       exp_q[$];
  bit         m_locked;
  bit         m_ovf;
  logic [7:0] m_win;
  bit         m_cur[$];
  int         m_wcnt;

  function automatic void model_reset();
    exp_q.delete();
    m_cur.delete();
    m_locked = 0;
    m_ovf    = 0;
    m_win    = 8'h00;
    m_wcnt   = 0;
  endfunction

  function automatic void model_step(bit b, bit v, bit r, bit c);
    int         pre;
    bit         pop;
    bit         drop;
    logic [7:0] word;
    ent_t       x;
    pre  = exp_q.size();
    pop  = (pre > 0) && r;
    drop = 0;
    if (pop) void'(exp_q.pop_front());
    if (v) begin
      if (!m_locked) begin
        m_win = 8'((m_win << 1) | 8'(b));
        if (m_win == SYNC) begin
          m_locked = 1;
          m_wcnt   = 0;
          m_cur.delete();
        end
      end else begin
        m_cur.push_back(b);
        if (m_cur.size() == N) begin
          word = 8'h00;
          foreach (m_cur[i]) word = 8'((word << 1) | 8'(m_cur[i]));
          m_cur.delete();
          if (pre == 2 && !pop) begin
            drop     = 1;
            m_locked = 0;
            m_win    = 8'h00;
          end else begin
            x.d = word;
            x.s = (m_wcnt == 0);
            x.e = (m_wcnt == FW - 1);
            exp_q.push_back(x);
            if (m_wcnt == FW - 1) begin
              m_locked = 0;
              m_win    = 8'h00;
            end else begin
              m_wcnt++;
            end
          end
        end
      end
    end
    if (drop) m_ovf = 1;
    else if (c) m_ovf = 0;
  endfunction

  task automatic rnd_cycle(input bit b, input bit v, input bit r, input bit c);
    model_step(b, v, r, c);
    step(b, v, r, c);
    chk("rnd.valid", bus.word_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("rnd.data",  bus.word_data,   exp_q[0].d);
      chk("rnd.start", bus.frame_start, exp_q[0].s);
      chk("rnd.end",   bus.frame_end,   exp_q[0].e);
    end
    chk("rnd.locked", locked,   m_locked);
    chk("rnd.ovf",    overflow, m_ovf);
  endtask

  // ---------------- test sequence ----------------
  bit         stream[$];
  logic [7:0] w8;
  logic [7:0] wb;
  int         rdy_pct;
  bit         b, v, r, c;

  initial begin
    do_reset("rst0");

    // continuous frame, then bit_valid toggling
    tbl.delete();
    build_frame(0);
    run_table("cont");
    do_reset("rst1");
    tbl.delete();
    build_frame(1);
    run_table("tog");

    // word_ready held low for a whole frame
    do_reset("rst2");
    send_word(8'hA5, 0);
    chk("bp.locked", locked, 1);
    send_word(8'h11, 0);
    chk("bp.w11.valid", bus.word_valid, 1);
    chk("bp.w11.data",  bus.word_data, 8'h11);
    chk("bp.w11.start", bus.frame_start, 1);
    send_word(8'h22, 0);
    chk("bp.w22.head", bus.word_data, 8'h11);
    chk("bp.w22.ovf",  overflow, 0);
    send_word(8'h33, 0);
    chk("bp.w33.ovf",    overflow, 1);
    chk("bp.w33.locked", locked, 0);
    chk("bp.w33.head",   bus.word_data, 8'h11);
    send_word(8'h44, 0);
    chk("bp.w44.valid",  bus.word_valid, 1);
    chk("bp.w44.head",   bus.word_data, 8'h11);
    chk("bp.w44.locked", locked, 0);
    step(0, 0, 1, 0);
    chk("bp.pop1.data",  bus.word_data, 8'h22);
    chk("bp.pop1.start", bus.frame_start, 0);
    step(0, 0, 1, 0);
    chk("bp.pop2.valid", bus.word_valid, 0);
    chk("bp.pop2.ovf",   overflow, 1);

    // new drop coinciding with clear_ovf, then clear_ovf alone
    send_word(8'hA5, 0);
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    wb = 8'h33;
    for (int i = 7; i >= 1; i--) step(wb[i], 1, 0, 0);
    step(wb[0], 1, 0, 1);
    chk("ovfclr.same", overflow, 1);
    chk("ovfclr.locked", locked, 0);
    step(0, 0, 0, 1);
    chk("ovfclr.alone", overflow, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("ovfclr.drained", bus.word_valid, 0);

    // full buffer with a pop in the same cycle the next word completes
    do_reset("rst3");
    send_word(8'hA5, 0);
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    wb = 8'h33;
    for (int i = 7; i >= 1; i--) step(wb[i], 1, 0, 0);
    step(wb[0], 1, 1, 0);
    chk("pp.ovf",    overflow, 0);
    chk("pp.head",   bus.word_data, 8'h22);
    chk("pp.locked", locked, 1);
    wb = 8'h44;
    step(wb[7], 1, 1, 0);
    chk("pp.head33", bus.word_data, 8'h33);
    for (int i = 6; i >= 0; i--) step(wb[i], 1, 1, 0);
    chk("pp.w44.data",   bus.word_data, 8'h44);
    chk("pp.w44.end",    bus.frame_end, 1);
    chk("pp.w44.locked", locked, 0);

    // asynchronous reset in the middle of a frame
    do_reset("rst4");
    send_word(8'hA5, 0);
    send_word(8'h11, 0);
    wb = 8'h22;
    for (int i = 7; i >= 5; i--) step(wb[i], 1, 0, 0);
    reset = 1'b1;
    #2;
    chk_zero("midrst.async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_zero("midrst.rel");
    for (int k = 0; k < 2; k++) begin
      wb = (k == 0) ? 8'h22 : 8'h33;
      for (int i = 7; i >= 0; i--) begin
        step(wb[i], 1, 1, 0);
        chk("midrst.valid",  bus.word_valid, 0);
        chk("midrst.locked", locked, 0);
      end
    end

    // randomized streams against the reference model
    do_reset("rst5");
    model_reset();
    for (int f = 0; f < 30; f++) begin
      int junk;
      junk = $urandom_range(0, 12);
      for (int i = 0; i < junk; i++) stream.push_back(bit'($urandom_range(0, 1)));
      for (int i = 7; i >= 0; i--) stream.push_back(SYNC[i]);
      for (int k = 0; k < FW; k++) begin
        w8 = 8'($urandom_range(0, 255));
        for (int i = 7; i >= 0; i--) stream.push_back(w8[i]);
      end
    end
    rdy_pct = 100;
    for (int cyc = 0; stream.size() > 0 || cyc < 20; cyc++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 2))
          0:       rdy_pct = 100;
          1:       rdy_pct = 70;
          default: rdy_pct = 15;
        endcase
      end
      v = (stream.size() > 0) && ($urandom_range(0, 3) != 0);
      b = v ? stream.pop_front() : bit'($urandom_range(0, 1));
      r = ($urandom_range(0, 99) < rdy_pct);
      c = ($urandom_range(0, 15) == 0);
      rnd_cycle(b, v, r, c);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/s2p_frame_ctrl.md
S2P_FRAME_CTRL -- requirements
Module: s2p_frame_ctrl

Interface
REQ-001 Parameter N, default 8: word width in bits; legal range 2..32.
REQ-002 Parameter SYNC, default 8'hA5: N-bit sync pattern that opens a frame.
REQ-003 Parameter FRAME_WORDS, default 4: payload words per frame; legal range 1..255.
REQ-004 clk  input  1  clock; all state SHALL be updated on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 bit_in  input  1  serial data bit, MSB of each word first.
REQ-007 bit_valid  input  1  bit_in SHALL be sampled only in cycles where bit_valid=1.
REQ-008 word_ready  input  1  downstream accepts the head word this cycle.
REQ-009 clear_ovf  input  1  clears the sticky overflow flag.
REQ-010 word_data  output  N  parallel word at the head of the output buffer.
REQ-011 word_valid  output  1  word_data, frame_start and frame_end are valid.
REQ-012 frame_start  output  1  head word is word 0 of its frame.
REQ-013 frame_end  output  1  head word is word FRAME_WORDS-1 of its frame.
REQ-014 locked  output  1  high while in state PAYLOAD.
REQ-015 overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-016 The block SHALL implement two states, HUNT and PAYLOAD.
REQ-017 HUNT: each sampled bit SHALL shift into an N-bit register as {sr[N-2:0], bit_in}; when the post-shift value equals SYNC, the state SHALL move to PAYLOAD with bit count 0 and word count 0.
REQ-018 Sync detection SHALL be bit-aligned at any offset; the sync word itself SHALL NOT be emitted.
REQ-019 PAYLOAD: sampled bits SHALL assemble MSB-first; on the Nth sampled bit the completed word SHALL be pushed to the output buffer, tagged with frame_start=(word count==0) and frame_end=(word count==FRAME_WORDS-1).
REQ-020 After pushing word FRAME_WORDS-1, the state SHALL return to HUNT with the shift register cleared to 0.
REQ-021 Cycles with bit_valid=0 SHALL leave all counters, registers and state unchanged.
REQ-022 Output buffer SHALL be a 2-entry FIFO; word_valid=1 whenever it is non-empty; the head entry SHALL drive word_data/frame_start/frame_end.
REQ-023 A pop SHALL occur when word_valid and word_ready are both 1; word_data SHALL be held stable while word_valid=1 and word_ready=0.
REQ-024 Latency: a word SHALL appear on word_valid in the cycle after its final bit is sampled, if the buffer was empty.
REQ-025 Push and pop in the same cycle SHALL both take effect, including when the buffer holds 2 entries (no overflow).
REQ-026 A push while the buffer holds 2 entries and no pop occurs SHALL drop the word, set overflow, and force state to HUNT with the shift register cleared (resync).
REQ-027 overflow SHALL clear on clear_ovf=1; a simultaneous set event SHALL win over clear_ovf.
REQ-028 locked SHALL equal (state==PAYLOAD), registered.
REQ-029 Counters SHALL be sized to hold N-1 and FRAME_WORDS-1; no wrap-around beyond those values shall occur.

Reset
REQ-030 Reset SHALL force state HUNT, shift register, bit count and word count to 0, and empty the FIFO.
REQ-031 During and after reset: word_valid=0, frame_start=0, frame_end=0, locked=0, overflow=0, word_data=0.
REQ-032 Reset asserted mid-frame SHALL discard the partial word and buffered words; no word emitted after deassertion until a new SYNC is seen.

Verification
REQ-033 Defaults, word_ready=1: bits 0,1,1 then A5, 11, 22, 33, 44 continuous -> locked after A5; words 11(start),22,33,44(end) each one cycle after final bit; locked=0 after 44.
REQ-034 bit_valid toggled 1/0 every cycle through a full frame -> identical words and tags to REQ-033, spaced 2x.
REQ-035 word_ready=0 for whole frame -> 11,22 buffered, 33 dropped, overflow=1, locked=0; 44 not emitted; word_data holds 11.
REQ-036 overflow=1 with clear_ovf=1 in the same cycle as a new drop -> overflow stays 1; clear_ovf alone next cycle -> overflow=0.
REQ-037 Buffer full (11,22), word_ready=1 in the cycle 33 completes -> 11 popped, 33 accepted, overflow stays 0.
REQ-038 reset pulse after 3 bits of word 22 -> all outputs 0; stream 22,33 without SYNC -> no word_valid.
